// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage : execute stage of the 5-stage LoongArch pipeline.
//
// Latches one decoded instruction from the decode stage, computes the ALU
// result, issues at most one data-SRAM request for ld.w/st.w and hands the
// result on to the memory stage.
//
// Ports
//   clk, resetn           pipeline clock, asynchronous active-low reset
//   ds_to_es_valid/bus    instruction from decode (bus MSB-first:
//                         alu_op[12], load_op, src1_is_pc, src2_is_imm,
//                         src2_is_4, gr_we, mem_we, dest[5], imm[32],
//                         rj_value[32], rkd_value[32], pc[32], res_from_mem)
//   es_allowin            this stage can take a new instruction this cycle
//   es_to_ms_valid/bus    result toward memory stage (bus MSB-first:
//                         res_from_mem, gr_we, dest[5], alu_result[32], pc[32])
//   ms_allowin            memory stage can accept this cycle
//   data_sram_*           request channel; a request is taken on the cycle
//                         where data_sram_req && data_sram_addr_ok
//   es_fwd_bus            {valid, dest[5], data[32]} bypass toward decode,
//                         present only when EXE_FORWARD_EN is defined
//
// Handshake rule (both sides): a transfer happens on the rising clock edge
// where the producer's valid and the consumer's allowin/addr_ok are both high
// in the preceding cycle; a producer keeps valid and payload stable until
// that transfer happens.
//
// Optional feature macro: EXE_FORWARD_EN (adds es_fwd_bus).
// -----------------------------------------------------------------------------
module exe_stage #(
  parameter int DS_TO_ES_WD = 152,
  parameter int ES_TO_MS_WD = 71
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ms_allowin,
  output logic                   es_allowin,
  input  logic                   ds_to_es_valid,
  input  logic [DS_TO_ES_WD-1:0] ds_to_es_bus,
  output logic                   es_to_ms_valid,
  output logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
  output logic                   data_sram_req,
  output logic                   data_sram_wr,
  output logic [1:0]             data_sram_size,
  output logic [3:0]             data_sram_wstrb,
  output logic [31:0]            data_sram_addr,
  output logic [31:0]            data_sram_wdata,
  input  logic                   data_sram_addr_ok
`ifdef EXE_FORWARD_EN
  ,
  output logic [38:0]            es_fwd_bus
`endif
);

  // Memory request state: REQ_DONE means this instruction's single request
  // has already been accepted and must not be issued again.
  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_DONE = 1'b1
  } req_state_t;

  req_state_t req_state;
  req_state_t req_state_next;
  logic       req_done;

  logic                   es_valid;
  logic [DS_TO_ES_WD-1:0] bus_r;
  logic                   es_ready_go;
  logic                   es_leave;

  // Decoded fields of the latched instruction
  logic [11:0] alu_op;
  logic        load_op;
  logic        src1_is_pc;
  logic        src2_is_imm;
  logic        gr_we;
  logic        mem_we;
  logic [4:0]  dest;
  logic [31:0] imm;
  logic [31:0] rj_value;
  logic [31:0] rkd_value;
  logic [31:0] pc;
  logic        res_from_mem;
  logic        is_mem;

  // Decode already folds the constant 4 into imm for bl-style instructions,
  // so this flag only occupies its slot in the bus layout.
  logic        unused_src2_is_4;

  assign alu_op           = bus_r[151:140];
  assign load_op          = bus_r[139];
  assign src1_is_pc       = bus_r[138];
  assign src2_is_imm      = bus_r[137];
  assign unused_src2_is_4 = bus_r[136];
  assign gr_we            = bus_r[135];
  assign mem_we           = bus_r[134];
  assign dest             = bus_r[133:129];
  assign imm              = bus_r[128:97];
  assign rj_value         = bus_r[96:65];
  assign rkd_value        = bus_r[64:33];
  assign pc               = bus_r[32:1];
  assign res_from_mem     = bus_r[0];
  assign is_mem           = load_op | mem_we;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  shamt;
  logic [31:0] add_result;
  logic [31:0] sub_result;
  logic        slt_result;
  logic        sltu_result;
  logic [31:0] sra_result;
  logic [31:0] alu_result;

  assign src1        = src1_is_pc  ? pc  : rj_value;
  assign src2        = src2_is_imm ? imm : rkd_value;
  assign shamt       = src2[4:0];
  assign add_result  = src1 + src2;
  assign sub_result  = src1 - src2;
  assign slt_result  = $signed(src1) < $signed(src2);
  assign sltu_result = src1 < src2;
  assign sra_result  = $unsigned($signed(src1) >>> shamt);

  // alu_op is one-hot; an all-zero op falls through to zero.
  always_comb begin
    alu_result = 32'd0;
    case (1'b1)
      alu_op[0]:  alu_result = add_result;
      alu_op[1]:  alu_result = sub_result;
      alu_op[2]:  alu_result = {31'd0, slt_result};
      alu_op[3]:  alu_result = {31'd0, sltu_result};
      alu_op[4]:  alu_result = src1 & src2;
      alu_op[5]:  alu_result = ~(src1 | src2);
      alu_op[6]:  alu_result = src1 | src2;
      alu_op[7]:  alu_result = src1 ^ src2;
      alu_op[8]:  alu_result = src1 << shamt;
      alu_op[9]:  alu_result = src1 >> shamt;
      alu_op[10]: alu_result = sra_result;
      alu_op[11]: alu_result = src2;
      default:    alu_result = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline flow control
  // ---------------------------------------------------------------------------
  // A memory instruction may leave in the same cycle its request is taken.
  assign es_ready_go    = !is_mem || req_done || (data_sram_req && data_sram_addr_ok);
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;
  assign es_leave       = es_to_ms_valid && ms_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  // Payload register carries no reset: it is only observed while es_valid.
  always_ff @(posedge clk) begin
    if (ds_to_es_valid && es_allowin) begin
      bus_r <= ds_to_es_bus;
    end
  end

  assign es_to_ms_bus = {res_from_mem, gr_we, dest, alu_result, pc};

  // ---------------------------------------------------------------------------
  // Memory request FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_state <= REQ_IDLE;
    end else begin
      req_state <= req_state_next;
    end
  end

  always_comb begin
    req_state_next = req_state;
    if (req_state == REQ_IDLE && data_sram_req && data_sram_addr_ok) begin
      req_state_next = REQ_DONE;
    end
    // Leaving wins over setting: a request taken in the leave cycle must not
    // block the next instruction.
    if (es_leave) begin
      req_state_next = REQ_IDLE;
    end
  end

  assign req_done = (req_state == REQ_DONE);

  // All request fields derive from bus_r, which is frozen while the stage is
  // stalled, so they hold stable until addr_ok.
  assign data_sram_req   = es_valid && is_mem && (req_state == REQ_IDLE);
  assign data_sram_wr    = mem_we;
  assign data_sram_size  = 2'd2;
  assign data_sram_wstrb = mem_we ? 4'hf : 4'h0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;

`ifdef EXE_FORWARD_EN
  // Loads are excluded: their data is not known until the memory stage.
  assign es_fwd_bus = {es_valid && gr_we && !res_from_mem && (dest != 5'd0),
                       dest, alu_result};
`endif

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage : self-checking bench for exe_stage.
// Directed cases followed by randomized instructions with random back-pressure
// on ms_allowin and data_sram_addr_ok. Expected memory-stage results and
// expected SRAM requests are queued when decode hands an instruction over; a
// monitor pops and compares whenever the DUT completes a transfer.
// -----------------------------------------------------------------------------
module tb_exe_stage;

  typedef struct {
    int          op;            // 0..11 selects an ALU operation, 12 = none
    logic        load_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_4;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic [31:0] pc;
    logic        res_from_mem;
  } instr_t;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic resetn;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [151:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic         data_sram_req;
  logic         data_sram_wr;
  logic [1:0]   data_sram_size;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;
`ifdef EXE_FORWARD_EN
  logic [38:0]  es_fwd_bus;
`endif

  exe_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_allowin        (ms_allowin),
    .es_allowin        (es_allowin),
    .ds_to_es_valid    (ds_to_es_valid),
    .ds_to_es_bus      (ds_to_es_bus),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok)
`ifdef EXE_FORWARD_EN
    ,
    .es_fwd_bus        (es_fwd_bus)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  logic [70:0] ms_exp_q[$];   // {res_from_mem, gr_we, dest, result, pc}
  logic [68:0] req_exp_q[$];  // {wr, wstrb, addr, wdata}

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: what each operation means arithmetically.
  function automatic logic [31:0] ref_result(input instr_t i);
    logic [31:0] a;
    logic [31:0] b;
    int          sh;
    a  = i.src1_is_pc  ? i.pc  : i.rj;
    b  = i.src2_is_imm ? i.imm : i.rkd;
    sh = int'(b % 32);
    case (i.op)
      0:       return a + b;
      1:       return a - b;
      2:       return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3:       return (a < b) ? 32'd1 : 32'd0;
      4:       return a & b;
      5:       return ~(a | b);
      6:       return a | b;
      7:       return a ^ b;
      8:       return a << sh;
      9:       return a >> sh;
      10:      return 32'(int'(a) >>> sh);
      11:      return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [151:0] encode(input instr_t i);
    logic [11:0] one;
    logic [11:0] opv;
    one = 12'd1;
    opv = (i.op < 12) ? (one << i.op) : 12'd0;
    return {opv, i.load_op, i.src1_is_pc, i.src2_is_imm, i.src2_is_4, i.gr_we,
            i.mem_we, i.dest, i.imm, i.rj, i.rkd, i.pc, i.res_from_mem};
  endfunction

  task automatic push_exp(input instr_t i);
    logic [31:0] r;
    r = ref_result(i);
    ms_exp_q.push_back({i.res_from_mem, i.gr_we, i.dest, r, i.pc});
    if (i.load_op || i.mem_we) begin
      req_exp_q.push_back({i.mem_we, (i.mem_we ? 4'hf : 4'h0), r, i.rkd});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Instruction builders
  // ---------------------------------------------------------------------------
  function automatic instr_t mk_alu(input int op, input logic [31:0] rj, input logic [31:0] rkd,
                                    input logic [31:0] imm, input logic use_imm,
                                    input logic [4:0] dest);
    instr_t i;
    i.op = op; i.load_op = 1'b0; i.src1_is_pc = 1'b0; i.src2_is_imm = use_imm;
    i.src2_is_4 = 1'b0; i.gr_we = 1'b1; i.mem_we = 1'b0; i.dest = dest;
    i.imm = imm; i.rj = rj; i.rkd = rkd; i.pc = 32'h1c00_0000; i.res_from_mem = 1'b0;
    return i;
  endfunction

  function automatic instr_t mk_load(input logic [31:0] rj, input logic [31:0] imm,
                                     input logic [4:0] dest);
    instr_t i;
    i = mk_alu(0, rj, 32'h5a5a_5a5a, imm, 1'b1, dest);
    i.load_op = 1'b1; i.res_from_mem = 1'b1; i.pc = 32'h1c00_0040;
    return i;
  endfunction

  function automatic instr_t mk_store(input logic [31:0] rj, input logic [31:0] imm,
                                      input logic [31:0] rkd);
    instr_t i;
    i = mk_alu(0, rj, rkd, imm, 1'b1, 5'd0);
    i.mem_we = 1'b1; i.gr_we = 1'b0; i.pc = 32'h1c00_0080;
    return i;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7fff_ffff;
      3:       return 32'h8000_0000;
      4:       return 32'hffff_ffff;
      default: return $urandom();
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int     kind;
    kind = $urandom_range(0, 2);
    i = mk_alu(int'($urandom_range(0, 12)), rand_val(), rand_val(), rand_val(),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    i.pc        = $urandom();
    i.src2_is_4 = 1'($urandom_range(0, 1));
    if (kind == 0) begin
      i.src1_is_pc = 1'($urandom_range(0, 1));
      i.gr_we      = 1'($urandom_range(0, 1));
    end else if (kind == 1) begin
      i.op = 0; i.src2_is_imm = 1'b1; i.load_op = 1'b1; i.res_from_mem = 1'b1;
    end else begin
      i.op = 0; i.src2_is_imm = 1'b1; i.mem_we = 1'b1; i.gr_we = 1'b0;
    end
    return i;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one cycle of decode-side and memory-side inputs. Inputs change on
  // the falling edge; acceptance is judged just after they settle.
  // ---------------------------------------------------------------------------
  task automatic cycle_drive(input logic v, input instr_t i, input logic msa,
                             input logic aok, output logic acc);
    @(negedge clk);
    ms_allowin        = msa;
    data_sram_addr_ok = aok;
    ds_to_es_valid    = v;
    if (v) begin
      ds_to_es_bus = encode(i);
    end else begin
      for (int k = 0; k < 152; k++) ds_to_es_bus[k] = 1'($urandom_range(0, 1));
    end
    #1;
    acc = v && es_allowin;
    if (acc) push_exp(i);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic        prev_wait;
  logic [68:0] prev_fields;

  initial begin
    logic [68:0] fields;
    logic [68:0] exp_req;
    logic [70:0] exp_ms;
    prev_wait   = 1'b0;
    prev_fields = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        prev_wait = 1'b0;
      end else begin
        fields = {data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata};
        if (prev_wait) begin
          check("req_hold", {1'b1, fields}, {1'b1, prev_fields});
          check("req_hold_valid", 71'(data_sram_req), 71'd1);
        end
        if (data_sram_req && data_sram_addr_ok) begin
          check("req_size", 71'(data_sram_size), 71'd2);
          if (req_exp_q.size() == 0) begin
            check("req_unexpected", 71'(fields), 71'd0);
          end else begin
            exp_req = req_exp_q.pop_front();
            check("req_fields", 71'(fields), 71'(exp_req));
          end
        end
        if (es_to_ms_valid && ms_allowin) begin
          if (ms_exp_q.size() == 0) begin
            check("ms_unexpected", es_to_ms_bus, 71'd0);
          end else begin
            exp_ms = ms_exp_q.pop_front();
            check("ms_bus", es_to_ms_bus, exp_ms);
          end
        end
        prev_wait   = data_sram_req && !data_sram_addr_ok;
        prev_fields = fields;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic alu_directed(input string name, input instr_t i, input logic [31:0] exp);
    logic acc;
    cycle_drive(1'b1, i, 1'b1, 1'b0, acc);
    check({name, "_acc"}, 71'(acc), 71'd1);
    cycle_drive(1'b0, i, 1'b1, 1'b0, acc);
    check({name, "_valid"}, 71'(es_to_ms_valid), 71'd1);
    check({name, "_result"}, 71'(es_to_ms_bus[63:32]), 71'(exp));
  endtask

  initial begin
    instr_t ins;
    logic   acc;
    int     n;

    resetn            = 1'b0;
    ms_allowin        = 1'b0;
    ds_to_es_valid    = 1'b0;
    ds_to_es_bus      = '0;
    data_sram_addr_ok = 1'b0;
    ins               = mk_alu(12, 0, 0, 0, 1'b0, 5'd0);

    // Reset state
    #3;
    check("rst_es_to_ms_valid", 71'(es_to_ms_valid), 71'd0);
    check("rst_req", 71'(data_sram_req), 71'd0);
    check("rst_es_allowin", 71'(es_allowin), 71'd1);
    @(negedge clk);
    @(negedge clk);
    #3 resetn = 1'b1;

    // add.w overflow wraps; one-cycle latency
    ins = mk_alu(0, 32'h7fff_ffff, 32'd1, 32'd0, 1'b0, 5'd5);
    alu_directed("add", ins, 32'h8000_0000);
    check("add_dest", 71'(es_to_ms_bus[68:64]), 71'd5);

    alu_directed("slt",  mk_alu(2, 32'hffff_ffff, 32'd1, 32'd0, 1'b0, 5'd6), 32'd1);
    alu_directed("sltu", mk_alu(3, 32'hffff_ffff, 32'd1, 32'd0, 1'b0, 5'd7), 32'd0);
    alu_directed("sra",  mk_alu(10, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 5'd8), 32'hf800_0000);

    // st.w with addr_ok low for three cycles
    ins = mk_store(32'h0000_1000, 32'd8, 32'hdead_beef);
    cycle_drive(1'b1, ins, 1'b1, 1'b0, acc);
    check("st_acc", 71'(acc), 71'd1);
    for (int c = 0; c < 3; c++) begin
      cycle_drive(1'b0, ins, 1'b1, 1'b0, acc);
      check("st_wait_req", 71'(data_sram_req), 71'd1);
      check("st_wait_addr", 71'(data_sram_addr), 71'h1008);
      check("st_wait_strb_wr", 71'({data_sram_wstrb, data_sram_wr}), 71'h1f);
      check("st_wait_no_valid", 71'(es_to_ms_valid), 71'd0);
    end
    cycle_drive(1'b0, ins, 1'b1, 1'b1, acc);
    check("st_accept_req", 71'(data_sram_req), 71'd1);
    check("st_accept_valid", 71'(es_to_ms_valid), 71'd1);
    cycle_drive(1'b0, ins, 1'b1, 1'b1, acc);
    check("st_after_req", 71'(data_sram_req), 71'd0);

    // ld.w accepted while memory stage stalls
    ins = mk_load(32'h0000_2000, 32'd4, 5'd9);
    cycle_drive(1'b1, ins, 1'b1, 1'b0, acc);
    check("ld_acc", 71'(acc), 71'd1);
    cycle_drive(1'b0, ins, 1'b0, 1'b1, acc);
    check("ld_req", 71'(data_sram_req), 71'd1);
    for (int c = 0; c < 2; c++) begin
      cycle_drive(1'b1, mk_alu(6, 32'h1, 32'h2, 32'h0, 1'b0, 5'd10), 1'b0, 1'b1, acc);
      check("ld_hold_no_acc", 71'(acc), 71'd0);
      check("ld_hold_req", 71'(data_sram_req), 71'd0);
      check("ld_hold_allowin", 71'(es_allowin), 71'd0);
      check("ld_hold_valid", 71'(es_to_ms_valid), 71'd1);
    end
    cycle_drive(1'b0, ins, 1'b1, 1'b1, acc);
    check("ld_go_valid", 71'(es_to_ms_valid), 71'd1);
    check("ld_go_res_from_mem", 71'(es_to_ms_bus[70]), 71'd1);
    check("ld_go_req", 71'(data_sram_req), 71'd0);

    // Back-to-back ld.w then add.w
    cycle_drive(1'b1, mk_load(32'h0000_3000, 32'd0, 5'd11), 1'b1, 1'b1, acc);
    check("b2b_ld_acc", 71'(acc), 71'd1);
    cycle_drive(1'b1, mk_alu(0, 32'd10, 32'd20, 32'd0, 1'b0, 5'd12), 1'b1, 1'b1, acc);
    check("b2b_add_acc", 71'(acc), 71'd1);
    check("b2b_ld_req", 71'(data_sram_req), 71'd1);
    cycle_drive(1'b0, ins, 1'b1, 1'b1, acc);
    check("b2b_add_valid", 71'(es_to_ms_valid), 71'd1);
    check("b2b_add_no_req", 71'(data_sram_req), 71'd0);

`ifdef EXE_FORWARD_EN
    // bl-style write to r0 must not forward
    cycle_drive(1'b1, mk_alu(0, 32'h1c00_0000, 32'd0, 32'd4, 1'b1, 5'd0), 1'b1, 1'b1, acc);
    cycle_drive(1'b0, ins, 1'b1, 1'b1, acc);
    check("fwd_r0_valid", 71'(es_fwd_bus[38]), 71'd0);
    cycle_drive(1'b1, mk_alu(7, 32'h0f0f_0f0f, 32'hffff_0000, 32'd0, 1'b0, 5'd3), 1'b1, 1'b1, acc);
    cycle_drive(1'b0, ins, 1'b1, 1'b1, acc);
    check("fwd_bus", 71'(es_fwd_bus), 71'({1'b1, 5'd3, 32'hf0f0_0f0f}));
`endif

    // Reset while a request waits for addr_ok
    ins = mk_store(32'h0000_4000, 32'd0, 32'h1234_5678);
    cycle_drive(1'b1, ins, 1'b1, 1'b0, acc);
    cycle_drive(1'b0, ins, 1'b1, 1'b0, acc);
    check("rst_mid_req_before", 71'(data_sram_req), 71'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_req", 71'(data_sram_req), 71'd0);
    check("rst_mid_es_valid", 71'(dut.es_valid), 71'd0);
    check("rst_mid_req_done", 71'(dut.req_done), 71'd0);
    check("rst_mid_allowin", 71'(es_allowin), 71'd1);
    ms_exp_q.delete();
    req_exp_q.delete();
    @(negedge clk);
    #3 resetn = 1'b1;

    // Randomized traffic with random back-pressure
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        cycle_drive(1'b0, ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      end
      ins = rand_instr();
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 64) begin
        cycle_drive(1'b1, ins, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) < 3), acc);
        n++;
      end
      check("rand_accept", 71'(acc), 71'd1);
    end

    // Drain
    n = 0;
    while ((ms_exp_q.size() != 0 || req_exp_q.size() != 0) && n < 40) begin
      cycle_drive(1'b0, ins, 1'b1, 1'b1, acc);
      n++;
    end
    cycle_drive(1'b0, ins, 1'b1, 1'b1, acc);
    check("drain_ms_q", 71'(ms_exp_q.size()), 71'd0);
    check("drain_req_q", 71'(req_exp_q.size()), 71'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage LoongArch pipeline. Sits between the decode stage and the memory stage.
- Latches the decoded instruction bus from decode and computes the ALU result.
- For ld.w/st.w, issues one data-SRAM request over a req/addr_ok handshake.
- Forwards result and control fields to the memory stage under valid/allowin flow control.

Parameters:
- DS_TO_ES_WD, 152, width of the incoming decode bus.
- ES_TO_MS_WD, 71, width of the outgoing memory-stage bus.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- ms_allowin  in  1  memory stage can accept this cycle
- es_allowin  out  1  this stage can accept this cycle
- ds_to_es_valid  in  1  decode presents a valid instruction
- ds_to_es_bus  in  152  MSB-first: alu_op[12], load_op, src1_is_pc, src2_is_imm, src2_is_4, gr_we, mem_we, dest[5], imm[32], rj_value[32], rkd_value[32], pc[32], res_from_mem
- es_to_ms_valid  out  1  valid toward memory stage
- es_to_ms_bus  out  71  MSB-first: res_from_mem, gr_we, dest[5], alu_result[32], pc[32]
- data_sram_req  out  1  data request valid
- data_sram_wr  out  1  1 = store, 0 = load
- data_sram_size  out  2  fixed 2'd2 (word)
- data_sram_wstrb  out  4  4'hf for store, 4'h0 for load
- data_sram_addr  out  32  equals alu_result
- data_sram_wdata  out  32  equals rkd_value
- data_sram_addr_ok  in  1  request accepted this cycle
- es_fwd_bus  out  39  {es_fwd_valid, es_fwd_dest[5], es_fwd_data[32]}; present only with the optional feature

Behaviour:
- Registers: es_valid, bus_r (152 bits), req_done.
- Asynchronous reset (resetn = 0): es_valid = 0, req_done = 0; bus_r is don't-care.
- Reset outputs: es_to_ms_valid = 0, data_sram_req = 0, es_allowin = 1.
- Handshake: es_allowin = !es_valid || (es_ready_go && ms_allowin); es_to_ms_valid = es_valid && es_ready_go.
- On es_allowin: es_valid <= ds_to_es_valid.
- bus_r loads only when ds_to_es_valid && es_allowin.
- Latency: one cycle from acceptance to es_to_ms_valid for non-memory instructions.
- Operand select: src1 = src1_is_pc ? pc : rj_value; src2 = src2_is_imm ? imm : rkd_value.
- ALU, alu_op one-hot, 32-bit, overflow ignored:
  - [0] add, [1] sub.
  - [2] slt signed, [3] sltu; result is 0 or 1 zero-extended.
  - [4] and, [5] nor, [6] or, [7] xor.
  - [8] sll, [9] srl, [10] sra; shift amount = src2[4:0].
  - [11] lui: result = src2.
  - All-zero alu_op gives result 0.
- is_mem = load_op | mem_we. Memory request FSM (req_done flag):
  - IDLE (req_done = 0): data_sram_req = es_valid && is_mem. On req && addr_ok, req_done <= 1.
  - DONE (req_done = 1): data_sram_req = 0, so at most one request per instruction.
  - req_done clears when the instruction leaves (es_to_ms_valid && ms_allowin). Leave has priority over set in the same cycle.
- es_ready_go = !is_mem || req_done || (data_sram_req && data_sram_addr_ok).
- Request fields hold stable while req is asserted and addr_ok is low.
- ms_allowin = 0 after acceptance: the stage holds, req_done stays 1, and no second request is issued.
- Invalid stage (es_valid = 0): data_sram_req = 0; bus contents are ignored.
- resetn asserted while waiting for addr_ok: the request drops immediately and the instruction is discarded.
- Address misalignment is not checked; the low address bits pass through unchanged.

Optional Feature:
- Macro: EXE_FORWARD_EN.
- Defined:
  - es_fwd_bus port exists.
  - es_fwd_valid = es_valid && gr_we && !res_from_mem && dest != 0.
  - es_fwd_dest = dest; es_fwd_data = alu_result. All combinational.
  - Feeds decode-stage bypass.
- Undefined: port absent; no added logic.

Test Plan:
- add.w, rj = 32'h7fffffff, rkd = 1, gr_we = 1, dest = 5, ms_allowin = 1 -> next cycle es_to_ms_valid = 1, alu_result = 32'h80000000, dest = 5.
- slt with rj = 32'hffffffff, rkd = 1 -> result 1; sltu, same operands -> result 0. sra with 32'h80000000 by imm 4 -> 32'hf8000000.
- st.w, rj = 32'h1000, imm = 8, addr_ok low for 3 cycles then high:
  - req = 1 for 4 cycles with addr = 32'h1008, wstrb = 4'hf, wr = 1.
  - es_to_ms_valid = 0 until the accept cycle; exactly one request accepted.
- ld.w accepted while ms_allowin = 0 for 2 cycles -> req drops after accept, es_allowin = 0, bus held; moves on when ms_allowin = 1; res_from_mem = 1 on es_to_ms_bus.
- Back-to-back: ld.w then add.w with addr_ok = 1 and ms_allowin = 1 -> one instruction per cycle, no bubble, req_done never blocks the second.
- resetn pulsed low mid-request -> es_valid, req_done, data_sram_req all 0 asynchronously. EXE_FORWARD_EN: bl-style gr_we with dest = 0 -> es_fwd_valid = 0.
